// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline memory stage.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: the valid/enable/fault flags update every cycle,
// while data and register index only change when a new bundle is loaded.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              valid_nxt,
  input  logic              reg_write_nxt,
  input  logic              misaligned_nxt,
  input  logic [REG_W-1:0]  write_reg_nxt,
  input  logic [WORD_W-1:0] data_nxt,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [WORD_W-1:0] wb_data,
  output logic              misaligned
);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misaligned   <= 1'b0;
      wb_write_reg <= '0;
      wb_data      <= '0;
    end else begin
      wb_valid     <= valid_nxt;
      wb_reg_write <= reg_write_nxt;
      misaligned   <= misaligned_nxt;
      if (load) begin
        wb_write_reg <= write_reg_nxt;
        wb_data      <= data_nxt;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word load/store over a req/ack handshake with stall.
// Define MEM_ALIGN_CHECK_EN to trap misaligned memory ops instead of issuing them.
//
// state  | meaning
// IDLE   | accepting EX/MEM; non-memory ops pass straight to write-back
// ACCESS | request outstanding to data memory, waiting for dmem_ack
module mem_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  write_reg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [WORD_W-1:0] wb_data,
  output logic              misaligned
);

  state_t state, state_nxt;

  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic              rw_q;
  logic [REG_W-1:0]  wreg_q;

  logic mem_op;
  logic align_fault;
  logic issue;

  logic              wb_load;
  logic              wb_valid_nxt;
  logic              wb_rw_nxt;
  logic              wb_mis_nxt;
  logic [REG_W-1:0]  wb_wreg_nxt;
  logic [WORD_W-1:0] wb_data_nxt;

  assign mem_op = ex_valid & (mem_read | mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault = mem_op & (alu_result[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign issue = mem_op & ~align_fault;

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    wb_load      = 1'b0;
    wb_valid_nxt = 1'b0;
    wb_rw_nxt    = 1'b0;
    wb_mis_nxt   = 1'b0;
    wb_wreg_nxt  = wreg_q;
    wb_data_nxt  = addr_q;
    case (state)
      IDLE: begin
        if (issue) begin
          stall     = 1'b1;
          state_nxt = ACCESS;
        end else if (ex_valid) begin
          // Plain ALU results and trapped misaligned ops both retire next cycle.
          wb_load      = 1'b1;
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = alu_result;
          wb_wreg_nxt  = write_reg;
          wb_rw_nxt    = reg_write & ~align_fault;
          wb_mis_nxt   = align_fault;
        end
      end
      ACCESS: begin
        stall = ~dmem_ack;
        if (dmem_ack) begin
          state_nxt    = IDLE;
          wb_load      = 1'b1;
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = we_q ? addr_q : dmem_rdata;
          wb_rw_nxt    = rw_q & ~we_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
      wreg_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && issue) begin
        addr_q  <= alu_result;
        wdata_q <= write_data;
        // A simultaneous read+write is carried out as a store.
        we_q    <= mem_write;
        rw_q    <= reg_write & ~mem_write;
        wreg_q  <= write_reg;
      end
    end
  end

  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = we_q;
  assign dmem_addr  = word_addr(addr_q);
  assign dmem_wdata = wdata_q;

  mem_wb_reg u_wb (
    .clk            (clk),
    .reset          (reset),
    .load           (wb_load),
    .valid_nxt      (wb_valid_nxt),
    .reg_write_nxt  (wb_rw_nxt),
    .misaligned_nxt (wb_mis_nxt),
    .write_reg_nxt  (wb_wreg_nxt),
    .data_nxt       (wb_data_nxt),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_write_reg   (wb_write_reg),
    .wb_data        (wb_data),
    .misaligned     (misaligned)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and queues the
// expected write-back bundles, a memory responder acks requests, a monitor checks.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        misaligned;

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .alu_result   (alu_result),
    .write_data   (write_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .wb_data      (wb_data),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        rw;
    logic [4:0]  wreg;
    logic        mis;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  wb_t         exp_q[$];
  req_t        req_q[$];
  int          lat_q[$];
  logic [31:0] model_mem[64];
  logic [31:0] resp_mem[64];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          resp_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_dmem_req"}, dmem_req, 0);
    check({tag, "_dmem_we"}, dmem_we, 0);
    check({tag, "_dmem_addr"}, dmem_addr, 0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_wb_reg_write"}, wb_reg_write, 0);
    check({tag, "_wb_write_reg"}, wb_write_reg, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_misaligned"}, misaligned, 0);
  endtask

  // Present one instruction (called just after a rising edge) and hold it
  // until the stage lets it advance.
  task automatic issue(input bit v, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input bit rw, input logic [4:0] wreg, input int k);
    bit memop, fault, done;
    int cnt, idx;
    ex_valid = v; mem_read = rd; mem_write = wr; alu_result = a;
    write_data = wd; reg_write = rw; write_reg = wreg;
    memop = v && (rd || wr);
`ifdef MEM_ALIGN_CHECK_EN
    fault = memop && ((a % 4) != 0);
`else
    fault = 1'b0;
`endif
    idx = (a / 4) % 64;
    if (v && !memop)
      exp_q.push_back('{data: a, rw: rw, wreg: wreg, mis: 1'b0});
    else if (fault)
      exp_q.push_back('{data: a, rw: 1'b0, wreg: wreg, mis: 1'b1});
    else if (memop) begin
      req_q.push_back('{addr: a & ~32'h3, we: wr, wdata: wd});
      lat_q.push_back(k);
      if (wr) begin
        model_mem[idx] = wd;
        exp_q.push_back('{data: a, rw: 1'b0, wreg: wreg, mis: 1'b0});
      end else
        exp_q.push_back('{data: model_mem[idx], rw: rw, wreg: wreg, mis: 1'b0});
    end
    if (memop && !fault) begin
      cnt = 0;
      done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
        @(negedge clk);
        if (stall === 1'b1) begin
          cnt++;
          @(posedge clk); #1;
        end else
          done = 1'b1;
      end
      check("stall_cycles", cnt, k);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      check("stall_low", stall, 0);
      @(posedge clk); #1;
    end
  endtask

  // Memory responder: acks the k-th cycle of each request, checks request fields.
  initial begin : responder
    int   cnt, k;
    req_t r;
    bit   last_ack;
    cnt = 0; k = 1; last_ack = 1'b0;
    r = '{addr: 32'h0, we: 1'b0, wdata: 32'h0};
    forever begin
      @(posedge clk); #2;
      if (resp_en) begin
        dmem_ack = 1'b0;
        if (last_ack) check("req_drop_after_ack", dmem_req, 0);
        last_ack = 1'b0;
        if (dmem_req === 1'b1) begin
          if (cnt == 0) begin
            if (lat_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL req_unexpected: got dmem_req=1, expected no request pending");
              k = 1;
              r = '{addr: 32'h0, we: 1'b0, wdata: 32'h0};
            end else begin
              k = lat_q.pop_front();
              r = req_q.pop_front();
            end
          end
          check("dmem_addr", dmem_addr, r.addr);
          check("dmem_we", dmem_we, r.we);
          if (r.we) check("dmem_wdata", dmem_wdata, r.wdata);
          cnt++;
          if (cnt >= k) begin
            dmem_ack = 1'b1;
            if (dmem_we) resp_mem[dmem_addr[7:2]] = dmem_wdata;
            else dmem_rdata = resp_mem[dmem_addr[7:2]];
            cnt = 0;
            last_ack = 1'b1;
          end else
            dmem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wb_unexpected: got wb_valid=1, expected no write-back pending");
        end else begin
          e = exp_q.pop_front();
          check("wb_reg_write", wb_reg_write, e.rw);
          check("wb_misaligned", misaligned, e.mis);
          if (!e.mis) begin
            check("wb_data", wb_data, e.data);
            check("wb_write_reg", wb_write_reg, e.wreg);
          end
        end
      end
    end
  end

  initial begin : driver
    int op, k;
    logic [31:0] a;
    reset = 1'b1; ex_valid = 1'b0; alu_result = '0; write_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; write_reg = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = $urandom;
      resp_mem[i]  = model_mem[i];
    end
    model_mem[0] = 32'hDEAD_BEEF;
    resp_mem[0]  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    issue(1, 0, 0, 32'h0000_0010, 32'h0, 1, 5'd8, 0);
    issue(1, 1, 0, 32'h0000_0100, 32'h0, 1, 5'd9, 3);
    issue(1, 0, 1, 32'h0000_0200, 32'h1234_5678, 1, 5'd10, 1);
    issue(1, 1, 1, 32'h0000_0044, 32'hCAFE_0001, 1, 5'd11, 2);
    issue(0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 0);
    issue(1, 1, 0, 32'h0000_0102, 32'h0, 1, 5'd12, 2);
    issue(1, 0, 0, 32'hFFFF_FFFF, 32'h0, 0, 5'd31, 0);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 5);
      k  = $urandom_range(1, 4);
      a  = (op >= 3) ? 32'($urandom_range(0, 255)) : $urandom;
      case (op)
        0:       issue(0, 0, 0, a, $urandom, 1'($urandom), 5'($urandom), k);
        1, 2:    issue(1, 0, 0, a, $urandom, 1'($urandom), 5'($urandom), k);
        3:       issue(1, 1, 0, a, $urandom, 1'($urandom), 5'($urandom), k);
        4:       issue(1, 0, 1, a, $urandom, 1'($urandom), 5'($urandom), k);
        default: issue(1, 1, 1, a, $urandom, 1'($urandom), 5'($urandom), k);
      endcase
    end
    repeat (3) issue(0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", lat_q.size(), 0);

    // Reset while a load is outstanding; the late ack must be ignored.
    resp_en = 1'b0;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h0000_0080;
    reg_write = 1'b1; write_reg = 5'd3;
    @(negedge clk);
    check("rst_access_accept_stall", stall, 1);
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("rst_access_req", dmem_req, 1);
    check("rst_access_addr", dmem_addr, 32'h0000_0080);
    reset = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_zero("rst_mid");
    reset = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_wb_valid", wb_valid, 0);
    check("late_ack_req", dmem_req, 0);
    @(posedge clk); #1;
    resp_en = 1'b1;

    issue(1, 0, 0, 32'h0000_0777, 32'h0, 1, 5'd4, 0);
    issue(1, 1, 0, 32'h0000_0008, 32'h0, 1, 5'd6, 2);
    repeat (3) issue(0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 0);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
